// File: rtl/mac_seq_pkg.sv
// Shared definitions for the mac_seq neuron sequencer.
// Holds the default parameter values, the derived neuron count and the
// sequencer state encoding used by mac_seq.
package mac_seq_pkg;

   localparam int unsigned DEF_NUM_WORDS = 40;
   localparam int unsigned DEF_WPN       = 4;
   localparam int unsigned DEF_DW        = 128;
   localparam int unsigned DEF_ACC_W     = 22;
   localparam int unsigned DEF_MAC_LAT   = 1;

   localparam int unsigned NEURONS = DEF_NUM_WORDS / DEF_WPN;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT_ACC,
      S_EMIT,
      S_FIN
   } state_t;

endpackage

// File: rtl/mac_argmax.sv
// Signed running maximum with its index.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : reload the most negative value and index 0
//   upd        : offer val/idx; taken only when val is strictly greater,
//                so ties keep the earlier (lower) index
//   max_idx    : index of the current maximum
module mac_argmax #(
   parameter int unsigned ACC_W = 22,
   parameter int unsigned IDX_W = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    upd,
   input  logic signed [ACC_W-1:0] val,
   input  logic [IDX_W-1:0]        idx,
   output logic [IDX_W-1:0]        max_idx
);

   localparam logic signed [ACC_W-1:0] MOST_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W-1:0] max_val;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         max_val <= MOST_NEG;
         max_idx <= '0;
      end else if (clr) begin
         max_val <= MOST_NEG;
         max_idx <= '0;
      end else if (upd && (val > max_val)) begin
         max_val <= val;
         max_idx <= idx;
      end
   end

endmodule

// File: rtl/mac_seq.sv
// Neuron sequencer: reads WPN operand words per neuron from an external
// memory, streams them to an external MAC, collects each accumulator result
// and offers it on a valid/ready port, tracking the argmax across the image.
//   start                : one-cycle image request (ignored while busy)
//   mem_rd/mem_addr      : operand read strobe and word address
//   p_rdata/w_rdata      : pixel/weight words, one cycle after mem_rd
//   mac_p/mac_w/mac_en   : registered operands to the MAC, mac_clr on word 0
//   acc_in               : MAC result, valid MAC_LAT cycles after last mac_en
//   res_data/res_idx     : neuron result and index, res_valid/res_ready
//   busy/done/class_out  : not idle, end-of-image pulse, argmax index
import mac_seq_pkg::*;

module mac_seq #(
   parameter int unsigned NUM_WORDS = DEF_NUM_WORDS,
   parameter int unsigned WPN       = DEF_WPN,
   parameter int unsigned DW        = DEF_DW,
   parameter int unsigned ACC_W     = DEF_ACC_W,
   parameter int unsigned MAC_LAT   = DEF_MAC_LAT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   output logic                    mem_rd,
   output logic [5:0]              mem_addr,
   input  logic [DW-1:0]           p_rdata,
   input  logic [DW-1:0]           w_rdata,
   output logic [DW-1:0]           mac_p,
   output logic [DW-1:0]           mac_w,
   output logic                    mac_en,
   output logic                    mac_clr,
   input  logic signed [ACC_W-1:0] acc_in,
   output logic signed [ACC_W-1:0] res_data,
   output logic [3:0]              res_idx,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic                    busy,
   output logic                    done,
   output logic [3:0]              class_out
);

   if ((NUM_WORDS % WPN) != 0) begin : g_bad_cfg
      $error("mac_seq: NUM_WORDS must be a multiple of WPN");
   end

   localparam int unsigned N_NEUR     = NUM_WORDS / WPN;
   localparam logic [5:0]  LAST_ADDR  = 6'(NUM_WORDS - 1);
   localparam logic [3:0]  LAST_NEUR  = 4'(N_NEUR - 1);
   localparam logic [7:0]  LAST_WORD  = 8'(WPN - 1);
   // WAIT_ACC is entered the cycle after the last read; the last mac_en
   // follows two cycles after that read (memory + operand register).
   localparam logic [7:0]  SAMPLE_CNT = 8'(MAC_LAT + 1);

   state_t     state, state_nxt;
   logic [7:0] wcnt;
   logic [5:0] addr;
   logic [3:0] nidx;
   logic       rd_d1, first_d1;
   logic       acc_smp, hs, img_start;

   assign img_start = (state == S_IDLE) && start;
   assign acc_smp   = (state == S_WAIT_ACC) && (wcnt == SAMPLE_CNT);
   assign hs        = (state == S_EMIT) && res_ready;

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:     if (start) state_nxt = S_FETCH;
         S_FETCH:    if (wcnt == LAST_WORD) state_nxt = S_WAIT_ACC;
         S_WAIT_ACC: if (acc_smp) state_nxt = S_EMIT;
         S_EMIT:     if (res_ready) state_nxt = (nidx == LAST_NEUR) ? S_FIN : S_FETCH;
         S_FIN:      state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   assign mem_rd    = (state == S_FETCH);
   assign mem_addr  = addr;
   assign res_valid = (state == S_EMIT);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_FIN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         wcnt  <= '0;
         addr  <= '0;
         nidx  <= '0;
      end else begin
         state <= state_nxt;
         // wcnt counts words in FETCH and latency cycles in WAIT_ACC
         if ((state == S_FETCH || state == S_WAIT_ACC) && state_nxt == state)
            wcnt <= wcnt + 8'd1;
         else
            wcnt <= '0;
         if (img_start)
            addr <= '0;
         else if (state == S_FETCH)
            addr <= (addr == LAST_ADDR) ? '0 : addr + 6'd1;
         if (img_start)
            nidx <= '0;
         else if (hs && nidx != LAST_NEUR)
            nidx <= nidx + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_d1    <= 1'b0;
         first_d1 <= 1'b0;
         mac_en   <= 1'b0;
         mac_clr  <= 1'b0;
         mac_p    <= '0;
         mac_w    <= '0;
         res_data <= '0;
         res_idx  <= '0;
      end else begin
         rd_d1    <= mem_rd;
         first_d1 <= mem_rd && (wcnt == 8'd0);
         mac_en   <= rd_d1;
         mac_clr  <= rd_d1 && first_d1;
         if (rd_d1) begin
            mac_p <= p_rdata;
            mac_w <= w_rdata;
         end
         if (acc_smp) begin
            res_data <= acc_in;
            res_idx  <= nidx;
         end
      end
   end

   mac_argmax #(
      .ACC_W(ACC_W),
      .IDX_W(4)
   ) u_argmax (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (img_start),
      .upd     (hs),
      .val     (res_data),
      .idx     (res_idx),
      .max_idx (class_out)
   );

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq with an operand memory and MAC model.
module tb_mac_seq;

   localparam int unsigned DW    = 128;
   localparam int unsigned ACC_W = 22;
   localparam logic [DW-1:0] WKEY = {4{32'hA5C3_5A3C}};

   logic             clk = 1'b0;
   logic             rst_n, start, res_ready;
   logic             mem_rd, mac_en, mac_clr, res_valid, busy, done;
   logic [5:0]       mem_addr;
   logic [DW-1:0]    p_rdata, w_rdata, mac_p, mac_w;
   logic signed [ACC_W-1:0] acc_in, res_data, acc;
   logic [3:0]       res_idx, class_out;

   logic [DW-1:0]    pmem [64];
   logic [DW-1:0]    wmem [64];
   int               vals [10];

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   // monitor state, written only by the monitor process
   int          start_cyc, first_rd, first_rd_addr, first_en, first_val;
   int          n_res, n_en, n_done, clr_bad, w_bad, max_addr;
   logic [3:0]  log_idx  [16];
   logic [21:0] log_data [16];

   typedef struct {
      logic [3:0]  idx;
      logic [21:0] data;
   } vec_t;
   vec_t vec [10];

   mac_seq #(
      .NUM_WORDS(40), .WPN(4), .DW(DW), .ACC_W(ACC_W), .MAC_LAT(1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .mem_rd(mem_rd), .mem_addr(mem_addr),
      .p_rdata(p_rdata), .w_rdata(w_rdata),
      .mac_p(mac_p), .mac_w(mac_w), .mac_en(mac_en), .mac_clr(mac_clr),
      .acc_in(acc_in), .res_data(res_data), .res_idx(res_idx),
      .res_valid(res_valid), .res_ready(res_ready),
      .busy(busy), .done(done), .class_out(class_out)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // external memory: one-cycle read latency
   always @(posedge clk) begin
      if (mem_rd) begin
         p_rdata <= pmem[mem_addr];
         w_rdata <= wmem[mem_addr];
      end
   end

   // external MAC: sum of pixel words, result one cycle after last mac_en
   always @(posedge clk) begin
      if (mac_en) acc <= mac_clr ? mac_p[ACC_W-1:0] : acc + mac_p[ACC_W-1:0];
   end
   assign acc_in = acc;

   initial begin
      p_rdata = '0;
      w_rdata = '0;
      acc     = '0;
   end

   always @(negedge clk) begin
      if (!rst_n || (start && !busy)) begin
         start_cyc = cyc; first_rd = -1; first_rd_addr = -1; first_en = -1;
         first_val = -1; n_res = 0; n_en = 0; n_done = 0; clr_bad = 0;
         w_bad = 0; max_addr = 0;
      end else begin
         if (mem_rd) begin
            if (first_rd < 0) begin first_rd = cyc; first_rd_addr = int'(mem_addr); end
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
         end
         if (mac_en) begin
            if (first_en < 0) first_en = cyc;
            if (mac_clr != ((n_en % 4) == 0)) clr_bad++;
            if (mac_w != (mac_p ^ WKEY)) w_bad++;
            n_en++;
         end else if (mac_clr) clr_bad++;
         if (res_valid && first_val < 0) first_val = cyc;
         if (res_valid && res_ready && n_res < 16) begin
            log_idx[n_res]  = res_idx;
            log_data[n_res] = res_data;
            n_res++;
         end
         if (done) n_done++;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic drv_edge();
      @(posedge clk); #1;
   endtask

   task automatic smp_edge();
      @(negedge clk); #1;
   endtask

   task automatic pulse_start();
      drv_edge(); start = 1'b1;
      drv_edge(); start = 1'b0;
   endtask

   task automatic wait_done(output bit ok, output logic [3:0] cls);
      ok = 1'b0; cls = '0;
      for (int i = 0; i < 400; i++) begin
         smp_edge();
         if (done) begin ok = 1'b1; cls = class_out; break; end
      end
   endtask

   task automatic wait_fetch(input int a, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         smp_edge();
         if (mem_rd && int'(mem_addr) == a) begin ok = 1'b1; break; end
      end
   endtask

   task automatic load_seq();
      for (int i = 0; i < 64; i++) begin
         pmem[i] = DW'(i);
         wmem[i] = DW'(i) ^ WKEY;
      end
   endtask

   task automatic load_vals();
      for (int i = 0; i < 64; i++) begin
         pmem[i] = '0;
         wmem[i] = WKEY;
      end
      for (int n = 0; n < 10; n++) begin
         pmem[4*n] = DW'(vals[n]);
         wmem[4*n] = DW'(vals[n]) ^ WKEY;
      end
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, 128'({mem_rd, mem_addr, mac_en, mac_clr, res_data, res_idx,
                      res_valid, busy, done, class_out}), 128'd0);
      chk({name, "_mac_p"}, mac_p, 128'd0);
      chk({name, "_mac_w"}, mac_w, 128'd0);
   endtask

   initial begin
      bit          ok;
      logic [3:0]  cls, hold_idx;
      logic [21:0] hold_data;
      int          bad_hold, bad_act, activity;

      // expected results for memory words 0..39: neuron n sums 4n..4n+3
      vec[0] = '{4'd0,  22'd6};   vec[1] = '{4'd1,  22'd22};
      vec[2] = '{4'd2,  22'd38};  vec[3] = '{4'd3,  22'd54};
      vec[4] = '{4'd4,  22'd70};  vec[5] = '{4'd5,  22'd86};
      vec[6] = '{4'd6,  22'd102}; vec[7] = '{4'd7,  22'd118};
      vec[8] = '{4'd8,  22'd134}; vec[9] = '{4'd9,  22'd150};

      rst_n = 1'b0; start = 1'b0; res_ready = 1'b1;
      load_seq();

      // reset held for 3 cycles
      repeat (3) drv_edge();
      smp_edge();
      chk_outs_zero("reset_outs");
      chk("reset_busy", 128'(busy), 128'd0);
      drv_edge(); rst_n = 1'b1;
      repeat (2) drv_edge();

      // single image
      pulse_start();
      wait_done(ok, cls);
      chk("img_done_seen", 128'(ok), 128'd1);
      chk("img_n_res", 128'(n_res), 128'd10);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("img_idx%0d", i), 128'(log_idx[i]), 128'(vec[i].idx));
         chk($sformatf("img_data%0d", i), 128'(log_data[i]), 128'(vec[i].data));
      end
      chk("lat_mem_rd", 128'(first_rd - start_cyc), 128'd1);
      chk("lat_mac_en", 128'(first_en - start_cyc), 128'd3);
      chk("lat_res_valid", 128'(first_val - start_cyc), 128'd8);
      chk("first_addr", 128'(first_rd_addr), 128'd0);
      chk("max_addr", 128'(max_addr), 128'd39);
      chk("n_mac_en", 128'(n_en), 128'd40);
      chk("mac_clr_pattern", 128'(clr_bad), 128'd0);
      chk("mac_w_path", 128'(w_bad), 128'd0);
      chk("img_class", 128'(cls), 128'd9);
      repeat (4) smp_edge();
      chk("img_done_once", 128'(n_done), 128'd1);
      chk("img_idle", 128'(busy), 128'd0);
      chk("class_held", 128'(class_out), 128'd9);

      // backpressure on neuron 3
      pulse_start();
      wait_fetch(12, ok);
      chk("bp_reach_n3", 128'(ok), 128'd1);
      drv_edge(); res_ready = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         smp_edge();
         if (res_valid) begin ok = 1'b1; break; end
      end
      chk("bp_valid_seen", 128'(ok), 128'd1);
      hold_idx = res_idx; hold_data = res_data;
      chk("bp_idx", 128'(hold_idx), 128'd3);
      chk("bp_data", 128'(hold_data), 128'd54);
      bad_hold = 0; bad_act = 0;
      for (int i = 0; i < 20; i++) begin
         smp_edge();
         if (!res_valid || res_idx != hold_idx || res_data != hold_data) bad_hold++;
         if (mem_rd || mac_en) bad_act++;
      end
      chk("bp_stable", 128'(bad_hold), 128'd0);
      chk("bp_no_activity", 128'(bad_act), 128'd0);
      drv_edge(); res_ready = 1'b1;
      wait_done(ok, cls);
      chk("bp_done_seen", 128'(ok), 128'd1);
      chk("bp_n_res", 128'(n_res), 128'd10);
      chk("bp_data3", 128'(log_data[3]), 128'd54);
      chk("bp_data9", 128'(log_data[9]), 128'd150);

      // argmax: ties keep the lower index, signed compare
      vals = '{-5, 7, 7, -100, 0, 0, 0, 0, 0, 0};
      load_vals();
      pulse_start();
      wait_done(ok, cls);
      chk("am1_done_seen", 128'(ok), 128'd1);
      chk("am1_class", 128'(cls), 128'd1);
      chk("am1_data0", 128'(log_data[0]), 128'(22'h3FFFFB));
      chk("am1_data3", 128'(log_data[3]), 128'(22'h3FFF9C));

      vals = '{-10, -20, -3, -50, -7, -9, -2, -8, -4, -2};
      load_vals();
      pulse_start();
      wait_done(ok, cls);
      chk("am2_done_seen", 128'(ok), 128'd1);
      chk("am2_class", 128'(cls), 128'd6);

      // reset during fetch of neuron 5
      load_seq();
      pulse_start();
      wait_fetch(20, ok);
      chk("rst_reach_n5", 128'(ok), 128'd1);
      drv_edge(); rst_n = 1'b0;
      #1;
      chk_outs_zero("midrst_outs");
      repeat (2) drv_edge();
      rst_n = 1'b1;
      activity = 0;
      for (int i = 0; i < 6; i++) begin
         smp_edge();
         if (res_valid || busy || mem_rd || mac_en || done) activity++;
      end
      chk("midrst_quiet", 128'(activity), 128'd0);
      pulse_start();
      wait_done(ok, cls);
      chk("restart_done_seen", 128'(ok), 128'd1);
      chk("restart_addr0", 128'(first_rd_addr), 128'd0);
      chk("restart_idx0", 128'(log_idx[0]), 128'd0);
      chk("restart_data0", 128'(log_data[0]), 128'd6);
      chk("restart_n_res", 128'(n_res), 128'd10);
      chk("restart_class", 128'(cls), 128'd9);

      // start while busy is ignored
      pulse_start();
      repeat (6) drv_edge();
      start = 1'b1;
      drv_edge(); start = 1'b0;
      wait_done(ok, cls);
      chk("ign_done_seen", 128'(ok), 128'd1);
      repeat (5) smp_edge();
      chk("ign_n_res", 128'(n_res), 128'd10);
      chk("ign_done_once", 128'(n_done), 128'd1);
      chk("ign_idle", 128'(busy), 128'd0);
      chk("ign_data9", 128'(log_data[9]), 128'd150);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
